// File: rtl/pxd_multi_align.sv
// pxd_multi_align: per-line quadrant sample select with hazard-count phase training.
// Training accumulates per-quadrant edge hazards over a window and keeps the quietest quadrant.
module pxd_multi_align #(
    parameter int NUM_LINES   = 12,
    parameter int WINDOW_LOG2 = 10,
    parameter int ERR_W       = 16
) (
    input  logic                   mclk,
    input  logic                   rst_n,
    input  logic [4*NUM_LINES-1:0] din,
    input  logic [1:0]             quadrant_manual,
    input  logic                   auto_en,
    input  logic                   train_start,
    input  logic                   train_abort,
    output logic [NUM_LINES-1:0]   dout,
    output logic [1:0]             quadrant_cur,
    output logic [1:0]             quadrant_best,
    output logic [ERR_W-1:0]       best_err,
    output logic                   train_busy,
    output logic                   train_done
);

    localparam int PW = $clog2(NUM_LINES + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, CMP, DONE} state_t;

    state_t                 state, state_nx;
    logic [WINDOW_LOG2-1:0] cnt;
    logic [ERR_W-1:0]       err [4];
    logic [ERR_W:0]         sum [4];
    logic [PW-1:0]          h [4];
    logic [ERR_W-1:0]       min_err, cand_err;
    logic [1:0]             min_q, cand_q, cq;
    logic                   better;

    // a transition between the two neighbours of q means q sits on an edge
    always_comb begin
        for (int q = 0; q < 4; q++) begin
            h[q] = '0;
            for (int i = 0; i < NUM_LINES; i++)
                h[q] = h[q] + PW'(din[4*i + ((q + 3) & 3)] ^ din[4*i + ((q + 1) & 3)]);
            sum[q] = {1'b0, err[q]} + (ERR_W + 1)'(h[q]);
        end
    end

    // the window counter wraps to 0 on entering CMP, so its low bits index the quadrant
    assign cq       = cnt[1:0];
    assign better   = cq == 2'd0 || err[cq] < min_err;
    assign cand_err = better ? err[cq] : min_err;
    assign cand_q   = better ? cq : min_q;

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (train_start && !train_abort) ? ACCUM : IDLE;
            ACCUM:   state_nx = train_abort ? IDLE : (&cnt ? CMP : ACCUM);
            CMP:     state_nx = train_abort ? IDLE : (cq == 2'd3 ? DONE : CMP);
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        train_busy = state != IDLE;
        train_done = state == DONE;
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            dout          <= '0;
            quadrant_cur  <= '0;
            quadrant_best <= '0;
            best_err      <= '0;
            cnt           <= '0;
            min_err       <= '0;
            min_q         <= '0;
            for (int q = 0; q < 4; q++)
                err[q] <= '0;
        end else begin
            quadrant_cur <= auto_en ? quadrant_best : quadrant_manual;
            for (int i = 0; i < NUM_LINES; i++)
                dout[i] <= din[4*i + int'(quadrant_cur)];
            cnt <= (state == IDLE) ? '0 : cnt + 1'b1;
            for (int q = 0; q < 4; q++)
                if (state == IDLE && state_nx == ACCUM)
                    err[q] <= '0;
                else if (state == ACCUM)
                    err[q] <= sum[q][ERR_W] ? '1 : sum[q][ERR_W-1:0];
            if (state == CMP) begin
                min_err <= cand_err;
                min_q   <= cand_q;
            end
            if (state == CMP && state_nx == DONE) begin
                quadrant_best <= cand_q;
                best_err      <= cand_err;
            end
        end
    end

endmodule

// File: tb/tb_pxd_multi_align.sv
// tb_pxd_multi_align: table vectors, random selection traffic and training runs
// checked against a window-level hazard/argmin model.
module tb_pxd_multi_align;

    localparam int NL = 12;
    localparam int WL = 4;
    localparam int EW = 16;
    localparam int SW = 4;

    logic            mclk = 0;
    logic            rst_n = 0;
    logic [4*NL-1:0] din = '0;
    logic [1:0]      quadrant_manual = '0;
    logic            auto_en = 0, train_start = 0, train_abort = 0;
    logic [NL-1:0]   dout, dout_s;
    logic [1:0]      qcur, qcur_s, qbest, qbest_s;
    logic [EW-1:0]   berr;
    logic [SW-1:0]   berr_s;
    logic            busy, busy_s, done, done_s;

    int         vectors = 0, miscompares = 0;
    logic [1:0] exp_qcur, exp_best, exp_best_s;
    int         exp_berr, exp_berr_s;

    typedef struct {
        logic [3:0] pat;
        logic [1:0] q;
        logic       exp;
    } vec_t;
    vec_t tbl [8];

    always #5 mclk = ~mclk;

    pxd_multi_align #(.NUM_LINES(NL), .WINDOW_LOG2(WL), .ERR_W(EW)) u_dut (
        .mclk(mclk), .rst_n(rst_n), .din(din), .quadrant_manual(quadrant_manual),
        .auto_en(auto_en), .train_start(train_start), .train_abort(train_abort),
        .dout(dout), .quadrant_cur(qcur), .quadrant_best(qbest), .best_err(berr),
        .train_busy(busy), .train_done(done)
    );

    pxd_multi_align #(.NUM_LINES(NL), .WINDOW_LOG2(WL), .ERR_W(SW)) u_sat (
        .mclk(mclk), .rst_n(rst_n), .din(din), .quadrant_manual(quadrant_manual),
        .auto_en(auto_en), .train_start(train_start), .train_abort(train_abort),
        .dout(dout_s), .quadrant_cur(qcur_s), .quadrant_best(qbest_s), .best_err(berr_s),
        .train_busy(busy_s), .train_done(done_s)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NL-1:0] sel(input logic [4*NL-1:0] d, input logic [1:0] q);
        logic [NL-1:0] r;
        for (int i = 0; i < NL; i++) r[i] = d[4*i + int'(q)];
        return r;
    endfunction

    function automatic int hz(input logic [4*NL-1:0] d, input int q);
        int n = 0;
        for (int i = 0; i < NL; i++)
            if (d[4*i + (q + 3) % 4] != d[4*i + (q + 1) % 4]) n++;
        return n;
    endfunction

    function automatic logic [4*NL-1:0] gen_din(input logic [3:0] pat, input int k);
        logic [4*NL-1:0] d;
        logic [3:0]      n;
        for (int i = 0; i < NL; i++) begin
            n = 4'($urandom);
            if (pat == 4'hF) n[2] = n[0];
            else if (pat != 4'h0) n = k[0] ? pat : ~pat;
            d[4*i +: 4] = n;
        end
        return d;
    endfunction

    task automatic model_reset();
        exp_qcur = 0; exp_best = 0; exp_best_s = 0; exp_berr = 0; exp_berr_s = 0;
    endtask

    // one clock: dout reflects the inputs and quadrant_cur held before the edge
    task automatic tick();
        logic [4*NL-1:0] pd;
        logic            pa;
        logic [1:0]      pm;
        pd = din; pa = auto_en; pm = quadrant_manual;
        @(posedge mclk); #1;
        chk("dout", dout, sel(pd, exp_qcur));
        exp_qcur = pa ? exp_best : pm;
        chk("quadrant_cur", qcur, exp_qcur);
    endtask

    task automatic run_training(input logic [3:0] pat, input int abort_k, input int restart_k);
        int e [4];
        int es [4];
        int bq, bqs;
        logic [4*NL-1:0] d;
        for (int q = 0; q < 4; q++) begin e[q] = 0; es[q] = 0; end
        train_start = 1;
        tick();
        train_start = 0;
        for (int k = 1; k <= 21; k++) begin
            chk("busy", busy, 1);
            chk("busy_sat", busy_s, 1);
            chk("done", done, k == 21);
            if (k == 21) begin
                bq = 0; bqs = 0;
                for (int q = 1; q < 4; q++) begin
                    if (e[q] < e[bq]) bq = q;
                    if (es[q] < es[bqs]) bqs = q;
                end
                chk("best", qbest, bq);
                chk("best_err", berr, e[bq]);
                chk("done_sat", done_s, 1);
                chk("best_sat", qbest_s, bqs);
                chk("best_err_sat", berr_s, es[bqs]);
                exp_best = 2'(bq); exp_berr = e[bq]; exp_best_s = 2'(bqs); exp_berr_s = es[bqs];
            end
            if (k <= 16) begin
                d = gen_din(pat, k);
                din = d;
                for (int q = 0; q < 4; q++) begin
                    e[q]  = (e[q] + hz(d, q) > 65535) ? 65535 : e[q] + hz(d, q);
                    es[q] = (es[q] + hz(d, q) > 15) ? 15 : es[q] + hz(d, q);
                end
            end
            train_start = (k == restart_k);
            train_abort = (k == abort_k);
            if (k == abort_k) begin
                tick();
                train_abort = 0;
                chk("busy_after_abort", busy, 0);
                chk("busy_sat_after_abort", busy_s, 0);
                repeat (24) begin
                    tick();
                    chk("done_after_abort", done | done_s, 0);
                end
                chk("best_kept", qbest, exp_best);
                chk("best_err_kept", berr, exp_berr);
                chk("best_sat_kept", qbest_s, exp_best_s);
                chk("best_err_sat_kept", berr_s, exp_berr_s);
                return;
            end
            if (k < 21) tick();
        end
        train_start = 0;
        tick();
        chk("busy_end", busy | busy_s, 0);
        chk("done_end", done | done_s, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 1ms");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{4'b0100, 2'd2, 1'b1};
        tbl[1] = '{4'b0100, 2'd1, 1'b0};
        tbl[2] = '{4'b1000, 2'd3, 1'b1};
        tbl[3] = '{4'b0001, 2'd0, 1'b1};
        tbl[4] = '{4'b1110, 2'd0, 1'b0};
        tbl[5] = '{4'b1110, 2'd3, 1'b1};
        tbl[6] = '{4'b0010, 2'd1, 1'b1};
        tbl[7] = '{4'b1011, 2'd2, 1'b0};

        din = gen_din(0, 0);
        repeat (3) @(posedge mclk);
        #1;
        chk("rst_dout", dout | dout_s, 0);
        chk("rst_qcur", qcur | qcur_s, 0);
        chk("rst_best", qbest | qbest_s, 0);
        chk("rst_best_err", berr, 0);
        chk("rst_best_err_sat", berr_s, 0);
        chk("rst_busy", busy | busy_s, 0);
        chk("rst_done", done | done_s, 0);
        din = gen_din(0, 0);
        rst_n = 1;
        model_reset();
        repeat (4) begin tick(); din = gen_din(0, 0); end

        for (int v = 0; v < 8; v++) begin
            din = {NL{tbl[v].pat}};
            quadrant_manual = tbl[v].q;
            tick();
            chk("tbl_qcur", qcur, tbl[v].q);
            tick();
            chk("tbl_dout", dout, {NL{tbl[v].exp}});
        end

        repeat (60) begin
            din = gen_din(0, 0);
            auto_en = 1'($urandom);
            quadrant_manual = 2'($urandom);
            tick();
        end

        auto_en = 1;
        run_training(4'b0010, 0, 0);
        chk("hand_best_edge12", qbest, 1);
        chk("hand_best_err_edge12", berr, 0);
        run_training(4'b1110, 0, 0);
        chk("hand_best_edge01", qbest, 0);
        run_training(4'hF, 0, 0);
        run_training(4'h0, 0, 0);
        chk("hand_sat_best", qbest_s, 0);
        chk("hand_sat_err", berr_s, 15);
        run_training(4'b0010, 0, 3);
        run_training(4'h0, 5, 0);
        run_training(4'h0, 19, 0);
        run_training(4'b1110, 20, 0);
        chk("hand_best_after_aborts", qbest, 1);

        train_start = 1; train_abort = 1;
        tick();
        train_start = 0; train_abort = 0;
        chk("start_abort_busy", busy, 0);
        tick();
        chk("start_abort_done", done | busy, 0);

        train_start = 1;
        tick();
        train_start = 0;
        repeat (7) begin din = gen_din(0, 0); tick(); chk("busy_pre_reset", busy, 1); end
        #2 rst_n = 0;
        #1;
        chk("async_busy", busy | busy_s, 0);
        chk("async_done", done | done_s, 0);
        chk("async_best", qbest | qbest_s, 0);
        chk("async_best_err", berr, 0);
        chk("async_dout", dout, 0);
        chk("async_qcur", qcur, 0);
        @(posedge mclk); #1;
        rst_n = 1;
        model_reset();
        repeat (25) begin
            din = gen_din(0, 0);
            tick();
            chk("post_reset_idle", done | busy, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
